// File: rtl/binary_ram_pkg.sv
// Shared types and helpers for the binary_ram slice.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
//
// Contents:
//   ram_state_t - clear sequencer state (CLEAR, READY)
//   PAR_MAX_W   - widest data word the parity helper accepts
//   even_parity - even-parity bit of a zero-extended data word
package binary_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    localparam int PAR_MAX_W = 64;

    // Zero-extension does not change the XOR reduction, so callers pass
    // any word up to PAR_MAX_W bits cast to the full width.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every word address once after reset, then idles in READY.
// Latency: busy drops DEPTH cycles after the first cycle with rst=0.
// Backpressure: none; while busy the owning RAM ignores all accesses.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr_we    - write zero to clr_addr this cycle
//   clr_addr  - address being cleared
//   busy      - registered, 1 in CLEAR, 0 in READY
module ram_clear_seq
    import binary_ram_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        state;
    logic [ADDR_W-1:0] clr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    // The zero write to the last word lands on this same edge,
                    // so READY is entered with the whole array cleared.
                    if (clr_ptr == LAST_ADDR) begin
                        state   <= READY;
                        clr_ptr <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                READY: begin
                    busy <= 1'b0;
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we   = (state == CLEAR) && !rst;
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/binary_ram.sv
// Single-port RAM with registered read, self-clearing after reset, optional word parity.
// Latency: write at the accepting edge; read data and rd_valid one cycle after acceptance.
// Backpressure: busy=1 during the post-reset clear; accesses issued then are dropped.
//
// Ports: clk, rst (sync active-high), cs, rd_wr (1=read, 0=write), addr, wr_data,
//        rd_data, rd_valid, busy, par_err (only when RAM_PARITY_EN is defined).
// Build option: `define RAM_PARITY_EN stores an even-parity bit with every word.
module binary_ram
    import binary_ram_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rd_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy
`ifdef RAM_PARITY_EN
    ,
    output logic              par_err
`endif
);

`ifdef RAM_PARITY_EN
    localparam int WORD_W = WIDTH + 1;
`else
    localparam int WORD_W = WIDTH;
`endif

    // One extra bit so DEPTH itself is representable for the range check.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              in_range;
    logic              access_ok;
    logic              wr_en;
    logic              rd_en;

    ram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    assign in_range  = ({1'b0, addr} < DEPTH_L);
    assign access_ok = cs && !busy && !rst;
    assign wr_en     = access_ok && !rd_wr && in_range;
    assign rd_en     = access_ok && rd_wr;

`ifdef RAM_PARITY_EN
    assign wr_word = {even_parity(PAR_MAX_W'(wr_data)), wr_data};
`else
    assign wr_word = wr_data;
`endif

    // Only consumed when in_range is true, so the unguarded index is harmless.
    assign rd_word = mem[addr];

    // Storage carries no reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= (rd_en && in_range) ? rd_word[WIDTH-1:0] : '0;
        end
    end

`ifdef RAM_PARITY_EN
    // A correctly stored word has even total parity across data and parity bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= rd_en && in_range && (^rd_word);
        end
    end
`endif

endmodule
